// File: rtl/ps2_keypad_if.sv
// PS/2 keypad bus: the two PS/2 pins toward the receiver and the decoded
// keypad/scan outputs toward the CPU.
//   master : drives ps2_clk/ps2_data, observes the decoded outputs (PS/2 side / bench)
//   slave  : the receiver, samples the pins, drives the decoded outputs
interface ps2_keypad_if;
  logic        ps2_clk;
  logic        ps2_data;
  logic [15:0] keys;
  logic        key_event;
  logic [3:0]  key_code;
  logic        key_pressed;
  logic        scan_valid;
  logic [7:0]  scan_code;
  logic        frame_error;

  modport master (
    output ps2_clk, ps2_data,
    input  keys, key_event, key_code, key_pressed, scan_valid, scan_code, frame_error
  );

  modport slave (
    input  ps2_clk, ps2_data,
    output keys, key_event, key_code, key_pressed, scan_valid, scan_code, frame_error
  );
endinterface

// File: rtl/ps2_keypad.sv
// PS/2 keyboard receiver + Chip-8 hex keypad decoder.
//   clk          core clock, rising edge
//   res          asynchronous active-high reset
//   bus.ps2_*    raw PS/2 pins (asynchronous to clk)
//   bus.keys     held-key vector, bit n = Chip-8 key n down
//   bus.key_*    one-cycle key_event with held key_code/key_pressed
//   bus.scan_*   one-cycle scan_valid per good byte, held scan_code
//   bus.frame_error  one-cycle pulse on parity/stop/timeout error
// Latency: stop-bit fall at cycle S, scan_* at S+1, key outputs at S+2.
module ps2_keypad #(
  parameter int TIMEOUT = 25000
) (
  input logic clk,
  input logic res,
  ps2_keypad_if.slave bus
);

  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, SHIFT, PARITY, STOP} state_t;

  // Input synchronisers; idle-high bus so they reset to 1.
  logic clk_s1, clk_s2, clk_s3;
  logic dat_s1, dat_s2;
  logic fall, dat;

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      {clk_s1, clk_s2, clk_s3} <= 3'b111;
      {dat_s1, dat_s2}         <= 2'b11;
    end else begin
      clk_s1 <= bus.ps2_clk;
      clk_s2 <= clk_s1;
      clk_s3 <= clk_s2;
      dat_s1 <= bus.ps2_data;
      dat_s2 <= dat_s1;
    end
  end

  assign fall = clk_s3 & ~clk_s2;
  assign dat  = dat_s2;

  // Deframer
  state_t          state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [7:0]      sh_q, sh_d;
  logic            par_q, par_d;
  logic [TW-1:0]   to_q, to_d;
  logic            good_d, err_d;

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      to_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      to_q    <= to_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    par_d   = par_q;
    to_d    = '0;
    good_d  = 1'b0;
    err_d   = 1'b0;

    if (state_q != IDLE && !fall) to_d = to_q + TW'(1);

    case (state_q)
      IDLE: begin
        // A fall with data high is line noise, not a start bit.
        if (fall && !dat) begin
          state_d = SHIFT;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        if (fall) begin
          sh_d  = {dat, sh_q[7:1]};  // LSB arrives first
          cnt_d = 3'(cnt_q + 3'd1);
          if (cnt_q == 3'd7) state_d = PARITY;
        end
      end
      PARITY: begin
        if (fall) begin
          par_d   = dat;
          state_d = STOP;
        end
      end
      STOP: begin
        if (fall) begin
          state_d = IDLE;
          if (dat && (^sh_q ^ par_q)) good_d = 1'b1;
          else                        err_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Stalled device: drop the partial frame.
    if (state_q != IDLE && !fall && to_q == TW'(TIMEOUT - 1)) begin
      state_d = IDLE;
      err_d   = 1'b1;
      to_d    = '0;
    end
  end

  // Byte-level outputs (S+1)
  logic       scan_valid_q, frame_error_q;
  logic [7:0] scan_code_q;

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      scan_valid_q  <= 1'b0;
      frame_error_q <= 1'b0;
      scan_code_q   <= '0;
    end else begin
      scan_valid_q  <= good_d;
      frame_error_q <= err_d;
      if (good_d) scan_code_q <= sh_q;
    end
  end

  // Scancode set 2 -> Chip-8 key, {hit, key}
  function automatic logic [4:0] keymap(input logic [7:0] sc);
    case (sc)
      8'h16: keymap = {1'b1, 4'h1};
      8'h1E: keymap = {1'b1, 4'h2};
      8'h26: keymap = {1'b1, 4'h3};
      8'h25: keymap = {1'b1, 4'hC};
      8'h15: keymap = {1'b1, 4'h4};
      8'h1D: keymap = {1'b1, 4'h5};
      8'h24: keymap = {1'b1, 4'h6};
      8'h2D: keymap = {1'b1, 4'hD};
      8'h1C: keymap = {1'b1, 4'h7};
      8'h1B: keymap = {1'b1, 4'h8};
      8'h23: keymap = {1'b1, 4'h9};
      8'h2B: keymap = {1'b1, 4'hE};
      8'h1A: keymap = {1'b1, 4'hA};
      8'h22: keymap = {1'b1, 4'h0};
      8'h21: keymap = {1'b1, 4'hB};
      8'h2A: keymap = {1'b1, 4'hF};
      default: keymap = 5'd0;
    endcase
  endfunction

  // Decoder (S+2)
  logic        brk_q, ext_q;
  logic [15:0] keys_q;
  logic        key_event_q, key_pressed_q;
  logic [3:0]  key_code_q;
  logic [4:0]  hit;

  assign hit = keymap(scan_code_q);

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      brk_q         <= 1'b0;
      ext_q         <= 1'b0;
      keys_q        <= '0;
      key_event_q   <= 1'b0;
      key_pressed_q <= 1'b0;
      key_code_q    <= '0;
    end else begin
      key_event_q <= 1'b0;
      if (scan_valid_q) begin
        if (scan_code_q == 8'hF0) begin
          brk_q <= 1'b1;
        end else if (scan_code_q == 8'hE0) begin
          ext_q <= 1'b1;
        end else begin
          // Typematic repeats leave the bit unchanged and raise no event.
          if (!ext_q && hit[4] && keys_q[hit[3:0]] != ~brk_q) begin
            keys_q[hit[3:0]] <= ~brk_q;
            key_event_q      <= 1'b1;
            key_code_q       <= hit[3:0];
            key_pressed_q    <= ~brk_q;
          end
          brk_q <= 1'b0;
          ext_q <= 1'b0;
        end
      end
    end
  end

  assign bus.keys        = keys_q;
  assign bus.key_event   = key_event_q;
  assign bus.key_code    = key_code_q;
  assign bus.key_pressed = key_pressed_q;
  assign bus.scan_valid  = scan_valid_q;
  assign bus.scan_code   = scan_code_q;
  assign bus.frame_error = frame_error_q;

endmodule

// File: tb/tb_ps2_keypad.sv
module tb_ps2_keypad;

  localparam int TIMEOUT = 25000;
  localparam int HB      = 40;   // half PS/2 bit period in clk cycles
  localparam int GAP     = 200;

  logic clk = 1'b0;
  logic res = 1'b1;

  ps2_keypad_if bus ();

  ps2_keypad #(.TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .res (res),
    .bus (bus)
  );

  always #20 clk = ~clk;

  int total  = 0;
  int passed = 0;

  task automatic chk(input string name, input bit ok, input int act, input int exp);
    total++;
    if (ok) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Reference model: set-2 keypad semantics over a plain held-key table.
  typedef struct {
    int          code;
    bit          pressed;
    logic [15:0] keys;
  } ev_t;

  logic [7:0] map_sc [16] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h15, 8'h1D, 8'h24, 8'h2D,
                              8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h1A, 8'h22, 8'h21, 8'h2A};
  int         map_k  [16] = '{1, 2, 3, 12, 4, 5, 6, 13, 7, 8, 9, 14, 10, 0, 11, 15};

  bit   m_held [16];
  bit   m_brk, m_ext;
  int   err_exp;
  logic [7:0] scan_q [$];
  ev_t        ev_q   [$];

  function automatic logic [15:0] m_keys();
    logic [15:0] v = '0;
    for (int i = 0; i < 16; i++) v[i] = m_held[i];
    return v;
  endfunction

  function automatic void m_byte(input logic [7:0] b);
    int idx = -1;
    ev_t e;
    scan_q.push_back(b);
    if (b == 8'hF0) begin m_brk = 1; return; end
    if (b == 8'hE0) begin m_ext = 1; return; end
    for (int i = 0; i < 16; i++) if (map_sc[i] == b) idx = i;
    if (!m_ext && idx >= 0 && m_held[map_k[idx]] != !m_brk) begin
      m_held[map_k[idx]] = !m_brk;
      e.code = map_k[idx]; e.pressed = !m_brk; e.keys = m_keys();
      ev_q.push_back(e);
    end
    m_brk = 0; m_ext = 0;
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < 16; i++) m_held[i] = 0;
    m_brk = 0; m_ext = 0;
  endfunction

  // PS/2 line driver
  task automatic ps2_bit(input logic b);
    bus.ps2_data = b;
    repeat (HB) @(posedge clk);
    bus.ps2_clk = 1'b0;
    repeat (HB) @(posedge clk);
    bus.ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par);
    if (bad_par) err_exp++;
    else         m_byte(b);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(~^b ^ bad_par);
    ps2_bit(1'b1);
    bus.ps2_data = 1'b1;
    repeat (GAP) @(posedge clk);
    chk("keys_after_frame", bus.keys == m_keys(), bus.keys, m_keys());
  endtask

  task automatic partial_frame();
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(i[0]);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_keys"},        bus.keys == 16'h0,       bus.keys, 0);
    chk({tag, "_key_code"},    bus.key_code == 4'h0,    bus.key_code, 0);
    chk({tag, "_key_pressed"}, bus.key_pressed == 1'b0, bus.key_pressed, 0);
    chk({tag, "_scan_code"},   bus.scan_code == 8'h0,   bus.scan_code, 0);
    chk({tag, "_pulses"}, {bus.key_event, bus.scan_valid, bus.frame_error} == 3'b0,
        {bus.key_event, bus.scan_valid, bus.frame_error}, 0);
  endtask

  // Monitor: pops the model's expectations whenever the DUT presents output.
  always @(negedge clk) begin
    if (!res) begin
      if (bus.scan_valid) begin
        if (scan_q.size() == 0) chk("scan_unexpected", 0, bus.scan_code, 0);
        else begin
          automatic logic [7:0] e = scan_q.pop_front();
          chk("scan_code", bus.scan_code == e, bus.scan_code, e);
        end
      end
      if (bus.key_event) begin
        if (ev_q.size() == 0) chk("key_event_unexpected", 0, bus.key_code, 0);
        else begin
          automatic ev_t e = ev_q.pop_front();
          chk("key_code",    bus.key_code == 4'(e.code),  bus.key_code, e.code);
          chk("key_pressed", bus.key_pressed == e.pressed, bus.key_pressed, e.pressed);
          chk("event_keys",  bus.keys == e.keys,           bus.keys, e.keys);
        end
      end
      if (bus.frame_error) begin
        chk("frame_error_expected", err_exp > 0, 1, err_exp);
        if (err_exp > 0) err_exp--;
      end
    end
  end

  initial begin
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    m_reset();
    err_exp = 0;
    repeat (5) @(posedge clk);
    #1 chk_reset_vals("reset");
    @(posedge clk);
    res = 1'b0;
    repeat (10) @(posedge clk);

    // Make W, then typematic repeat, then break
    send_frame(8'h1D, 0);
    send_frame(8'h1D, 0);
    send_frame(8'hF0, 0);
    send_frame(8'h1D, 0);
    // Parity error, then a good key 1
    send_frame(8'h1D, 1);
    send_frame(8'h16, 0);
    // Extended prefix suppresses the next code only
    send_frame(8'hE0, 0);
    send_frame(8'h1D, 0);
    send_frame(8'h1D, 0);

    // Stalled frame, then key F
    err_exp++;
    partial_frame();
    bus.ps2_data = 1'b1;
    repeat (TIMEOUT + 100) @(posedge clk);
    chk("timeout_err_seen", err_exp == 0, err_exp, 0);
    send_frame(8'h2A, 0);

    // Randomized traffic
    for (int n = 0; n < 30; n++) begin
      automatic int r = $urandom_range(0, 9);
      automatic int k = $urandom_range(0, 15);
      if (r < 6)       send_frame(map_sc[k], 0);
      else if (r == 6) send_frame(8'hF0, 0);
      else if (r == 7) send_frame(8'hE0, 0);
      else if (r == 8) send_frame(8'($urandom_range(0, 255)), 0);
      else             send_frame(map_sc[k], 1);
    end

    // Reset mid-frame after pressing 1 and V
    send_frame(8'h16, 0);
    send_frame(8'h2A, 0);
    partial_frame();
    @(posedge clk);
    res = 1'b1;
    #1 chk_reset_vals("midreset");
    m_reset();
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    repeat (5) @(posedge clk);
    res = 1'b0;
    repeat (10) @(posedge clk);
    send_frame(8'h22, 0);
    chk("keys_after_reset_0x22", bus.keys == 16'h0001, bus.keys, 16'h0001);

    repeat (50) @(posedge clk);
    chk("scan_q_drained",  scan_q.size() == 0, scan_q.size(), 0);
    chk("event_q_drained", ev_q.size() == 0,   ev_q.size(), 0);
    chk("errors_drained",  err_exp == 0,       err_exp, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ps2_keypad.md
# ps2_keypad

PS/2 keyboard receiver and Chip-8 hex keypad decoder. Samples the PS/2 clock/data pair that user_io drives toward the core (~12 kHz bit rate), deframes 11-bit device-to-host frames, tracks make/break/extended prefixes, and maintains a 16-bit held-key vector for the Chip-8 CPU, plus per-key event pulses. Sits inside the chip8 machine between the ps2_clk/ps2_data pins and the CPU's keypad inputs (EX9E/EXA1/FX0A).

## Interface
- TIMEOUT, 25000: core clocks without a PS/2 falling edge before a partial frame is abandoned (1 ms at 25 MHz).
- clk  in  1  core clock (25 MHz), all logic on rising edge.
- res  in  1  asynchronous, active-high reset.
- ps2_clk  in  1  PS/2 clock, asynchronous to clk.
- ps2_data  in  1  PS/2 data, asynchronous to clk.
- keys  out  16  held state, bit n = Chip-8 key n is down.
- key_event  out  1  one-cycle pulse when a mapped key changes state.
- key_code  out  4  Chip-8 key of the last event; held until the next event.
- key_pressed  out  1  1 = last event was make, 0 = break; held.
- scan_valid  out  1  one-cycle pulse per good received byte.
- scan_code  out  8  last good byte; held.
- frame_error  out  1  one-cycle pulse on a parity/stop/timeout error.

## Operation
- Input sync: ps2_clk and ps2_data each pass through two flops; a third flop on ps2_clk gives falling-edge detect (fall = prev & ~sync).
- Deframer FSM states: IDLE, SHIFT, PARITY, STOP.
  - IDLE: on fall with data=0 -> SHIFT, bit count 0. Fall with data=1 is ignored (no error).
  - SHIFT: on each fall shift data into byte LSB-first; after the 8th bit -> PARITY.
  - PARITY: on fall capture bit; -> STOP.
  - STOP: on fall, if stop=1 and (^byte ^ parity)=1 (odd parity) the byte is good; otherwise frame_error pulses. Either way -> IDLE.
- Timeout: counter reset on every fall, counts in any state except IDLE; reaching TIMEOUT-1 -> IDLE with frame_error pulse; partial byte discarded.
- Decoder on a good byte:
  - 0xF0: set break flag, no key event.
  - 0xE0: set ext flag, no key event.
  - Other: if ext=0 and code is in the map, keys[n] <= ~break; key_event pulses only if keys[n] actually changes. Then clear break and ext. Unmapped or extended codes only clear the flags.
- Map (scancode -> key): 16->1, 1E->2, 26->3, 25->C, 15->4, 1D->5, 24->6, 2D->D, 1C->7, 1B->8, 23->9, 2B->E, 1A->A, 22->0, 21->B, 2A->F.
- Errors do not alter break/ext flags or keys.
- Typematic repeat (repeated make of a held key) gives scan_valid but no key_event.

## Timing
- Reset: FSM IDLE, flags 0, keys=0, key_code=0, key_pressed=0, scan_code=0, all pulses 0, sync flops 1 (bus idle high), timeout counter 0.
- Fall is detected 3 clk after ps2_clk falls at the pin. Data is sampled in the same cycle from the 2-flop synchronised ps2_data.
- The stop-bit fall and the FSM return to IDLE happen in the same cycle (cycle S). scan_valid and scan_code update at S+1. Keys, key_event, key_code and key_pressed update at S+2 (one-cycle registered decode).
- Minimum spacing between falls is ~2000 clk, so a decode never overlaps the next byte.
- Reset mid-frame: immediate return to reset state; the next frame must start with a fresh start bit.

## Test plan
- Frame 0x1D (W: start 0, bits 1,0,1,1,1,0,0,0, parity 1, stop 1) at 12 kHz -> scan_valid once with scan_code=0x1D; keys=0x0020; key_event with key_code=5, key_pressed=1.
- Sequence F0,1D after the above -> keys=0x0000; one key_event with key_code=5, key_pressed=0; no event on F0.
- 0x1D with parity bit flipped -> frame_error pulse, no scan_valid, keys unchanged. The next good 0x16 sets keys bit 1.
- Sequence E0,1D -> two scan_valid pulses, no key_event, keys unchanged. A following 0x1D still sets bit 5, which shows ext was cleared.
- ps2_clk stops after 4 data bits for more than 25000 clk -> frame_error pulse, FSM IDLE. The next full 0x2A frame sets keys bit 15.
- Press keys 1 and V, assert res mid-frame -> keys=0 and all outputs at reset values immediately. A subsequent 0x22 sets keys=0x0001.
